// File: rtl/adc_volt_meter.sv
// Multi-channel ADC voltmeter: block-averages signed samples per channel, scales to mV
// and converts to packed BCD through a per-channel iterative sequencer.
module adc_volt_meter #(
    parameter int unsigned CH_NUM   = 2,
    parameter int unsigned AD_WIDTH = 12,
    parameter int unsigned FS_MV    = 5000,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned DIGITS   = 4
) (
    input  logic                           ad_clk,
    input  logic                           rst,
    input  logic                           ad_valid,
    input  logic [CH_NUM*AD_WIDTH-1:0]     ad_data,
    output logic                           out_valid,
    output logic [2:0]                     out_ch,
    output logic [7:0]                     out_sig,
    output logic [$clog2(FS_MV+1)-1:0]     out_mv,
    output logic [4*DIGITS-1:0]            out_dec,
    output logic                           busy,
    output logic                           blk_drop
);

    localparam int unsigned MV_W     = $clog2(FS_MV + 1);
    localparam int unsigned HW       = AD_WIDTH + AVG_LOG2;
    localparam int unsigned PW       = HW + MV_W;
    localparam int unsigned CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned BLK_LAST = (1 << AVG_LOG2) - 1;
    localparam int unsigned BIT_W    = $clog2(MV_W + 1);
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int unsigned SR_W     = BCD_W + MV_W;
    localparam int unsigned SHIFT    = HW - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_MUL,
        S_SCALE,
        S_BCD,
        S_EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [HW-1:0]    acc_q [CH_NUM];
    logic signed [HW-1:0]    acc_d [CH_NUM];
    logic signed [HW-1:0]    hold_q [CH_NUM];
    logic signed [HW-1:0]    hold_d [CH_NUM];
    logic [2:0]              ch_q, ch_d;
    logic                    neg_q, neg_d;
    logic [HW-1:0]           mag_q, mag_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic [MV_W-1:0]         mv_q, mv_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    out_valid_q, out_valid_d;
    logic [2:0]              out_ch_q, out_ch_d;
    logic [7:0]              out_sig_q, out_sig_d;
    logic [MV_W-1:0]         out_mv_q, out_mv_d;
    logic [BCD_W-1:0]        out_dec_q, out_dec_d;
    logic                    busy_q, busy_d;
    logic                    blk_drop_q, blk_drop_d;

    logic signed [AD_WIDTH-1:0] samp [CH_NUM];
    logic                       blk_done;
    logic                       accept;
    logic [HW-1:0]              sel;
    logic signed [HW-1:0]       sum;
    logic [SR_W-1:0]            sr_nx;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_samp
        assign samp[g] = ad_data[g*AD_WIDTH +: AD_WIDTH];
    end

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[MV_W + 4*d +: 4] >= 4'd5) begin
                r[MV_W + 4*d +: 4] = r[MV_W + 4*d +: 4] + 4'd3;
            end
        end
        return r << 1;
    endfunction

    assign blk_done = ad_valid && (cnt_q == CNT_W'(BLK_LAST));
    assign accept   = blk_done && (state_q == S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        hold_d      = hold_q;
        ch_d        = ch_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        prod_d      = prod_q;
        mv_d        = mv_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_sig_d   = out_sig_q;
        out_mv_d    = out_mv_q;
        out_dec_d   = out_dec_q;
        blk_drop_d  = 1'b0;
        sel         = '0;
        sum         = '0;
        sr_nx       = dabble(sr_q);

        // Accumulate; a completing block always clears, but only snapshots when idle.
        if (ad_valid) begin
            cnt_d = blk_done ? '0 : cnt_q + CNT_W'(1);
            for (int k = 0; k < CH_NUM; k++) begin
                sum = acc_q[k] + HW'(samp[k]);
                if (blk_done) begin
                    acc_d[k] = '0;
                    if (accept) begin
                        hold_d[k] = sum;
                    end
                end else begin
                    acc_d[k] = sum;
                end
            end
            blk_drop_d = blk_done && !accept;
        end

        for (int k = 0; k < CH_NUM; k++) begin
            if (ch_q == 3'(k)) begin
                sel = hold_q[k];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ABS;
                    ch_d    = 3'd0;
                end
            end
            S_ABS: begin
                neg_d   = sel[HW-1];
                mag_d   = sel[HW-1] ? (~sel + HW'(1)) : sel;
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = PW'(mag_q) * PW'(FS_MV);
                state_d = S_SCALE;
            end
            S_SCALE: begin
                mv_d    = MV_W'(prod_q >> SHIFT);
                sr_d    = {{BCD_W{1'b0}}, MV_W'(prod_q >> SHIFT)};
                bit_d   = '0;
                state_d = S_BCD;
            end
            S_BCD: begin
                sr_d  = sr_nx;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(MV_W - 1)) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_ch_d    = ch_q;
                    out_sig_d   = neg_q ? 8'd45 : 8'd43;
                    out_mv_d    = mv_q;
                    out_dec_d   = sr_nx[SR_W-1 -: BCD_W];
                end
            end
            S_EMIT: begin
                if (ch_q == 3'(CH_NUM - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ABS;
                    ch_d    = ch_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                acc_q[k]  <= '0;
                hold_q[k] <= '0;
            end
            ch_q        <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            prod_q      <= '0;
            mv_q        <= '0;
            sr_q        <= '0;
            bit_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sig_q   <= 8'd43;
            out_mv_q    <= '0;
            out_dec_q   <= '0;
            busy_q      <= 1'b0;
            blk_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            hold_q      <= hold_d;
            ch_q        <= ch_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            prod_q      <= prod_d;
            mv_q        <= mv_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sig_q   <= out_sig_d;
            out_mv_q    <= out_mv_d;
            out_dec_q   <= out_dec_d;
            busy_q      <= busy_d;
            blk_drop_q  <= blk_drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sig   = out_sig_q;
    assign out_mv    = out_mv_q;
    assign out_dec   = out_dec_q;
    assign busy      = busy_q;
    assign blk_drop  = blk_drop_q;

endmodule

// File: tb/tb_adc_volt_meter.sv
// Randomised bench for adc_volt_meter: a default instance checked cycle by cycle against
// a block-level arithmetic model, plus a 4-channel/14-bit/no-averaging instance.
module tb_adc_volt_meter;

    localparam int CH    = 2;
    localparam int AW    = 12;
    localparam int FS    = 5000;
    localparam int AL    = 4;
    localparam int MVW   = 13;
    localparam int HW    = AW + AL;
    localparam int BLK   = 1 << AL;
    localparam int CONV  = CH * (4 + MVW);
    localparam int DW    = CH * AW;
    localparam int CH4   = 4;
    localparam int AW4   = 14;
    localparam int FS4   = 3300;
    localparam int MVW4  = 12;
    localparam int DW4   = CH4 * AW4;

    logic ad_clk = 1'b0;
    always #5 ad_clk = ~ad_clk;

    logic            rst;
    logic            ad_valid;
    logic [DW-1:0]   ad_data;
    logic            out_valid, busy, blk_drop;
    logic [2:0]      out_ch;
    logic [7:0]      out_sig;
    logic [MVW-1:0]  out_mv;
    logic [15:0]     out_dec;

    logic            ad_valid4;
    logic [DW4-1:0]  ad_data4;
    logic            out_valid4, busy4, blk_drop4;
    logic [2:0]      out_ch4;
    logic [7:0]      out_sig4;
    logic [MVW4-1:0] out_mv4;
    logic [15:0]     out_dec4;

    adc_volt_meter u_dut (
        .ad_clk(ad_clk), .rst(rst), .ad_valid(ad_valid), .ad_data(ad_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_sig(out_sig), .out_mv(out_mv),
        .out_dec(out_dec), .busy(busy), .blk_drop(blk_drop)
    );

    adc_volt_meter #(.CH_NUM(CH4), .AD_WIDTH(AW4), .FS_MV(FS4), .AVG_LOG2(0), .DIGITS(4)) u_dut4 (
        .ad_clk(ad_clk), .rst(rst), .ad_valid(ad_valid4), .ad_data(ad_data4),
        .out_valid(out_valid4), .out_ch(out_ch4), .out_sig(out_sig4), .out_mv(out_mv4),
        .out_dec(out_dec4), .busy(busy4), .blk_drop(blk_drop4)
    );

    int cyc = 0;
    always @(posedge ad_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: sign, truncated mV and decimal digits of one block sum.
    function automatic void ref_conv(input longint sum, input int hw, input int fs,
                                     output int sig, output int mv, output int dec);
        longint mag;
        int p;
        mag = (sum < 0) ? -sum : sum;
        sig = (sum < 0) ? 45 : 43;
        mv  = int'((mag * fs) / (longint'(1) << (hw - 1)));
        dec = 0;
        p   = 1;
        for (int d = 0; d < 4; d++) begin
            dec = dec | (((mv / p) % 10) << (4 * d));
            p   = p * 10;
        end
    endfunction

    function automatic longint sx(input logic [31:0] raw, input int w);
        return raw[w-1] ? longint'(raw) - (longint'(1) << w) : longint'(raw);
    endfunction

    typedef struct {
        int at;
        int ch;
        int sig;
        int mv;
        int dec;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc [CH];
    int     m_cnt;
    int     last_acc;
    int     drop_edge;
    int     n_acc_blk, n_drop, n_emit, n_drop_seen;

    task automatic model_reset();
        for (int k = 0; k < CH; k++) m_acc[k] = 0;
        m_cnt     = 0;
        exp_q.delete();
        last_acc  = -1000;
        drop_edge = -1;
    endtask

    // Sample taken at edge e; a completed block is accepted only once the previous conversion is over.
    task automatic model_sample(input logic [DW-1:0] d, input int e);
        int s, mv, dec;
        for (int k = 0; k < CH; k++) m_acc[k] += sx(32'(d[k*AW +: AW]), AW);
        m_cnt++;
        if (m_cnt == BLK) begin
            m_cnt = 0;
            if (e > last_acc + CONV) begin
                last_acc = e;
                n_acc_blk++;
                for (int k = 0; k < CH; k++) begin
                    ref_conv(m_acc[k], HW, FS, s, mv, dec);
                    exp_q.push_back('{e + 3 + MVW + k * (4 + MVW), k, s, mv, dec});
                end
            end else begin
                drop_edge = e;
                n_drop++;
            end
            for (int k = 0; k < CH; k++) m_acc[k] = 0;
        end
    endtask

    task automatic monitor();
        while (exp_q.size() > 0 && exp_q[0].at < cyc) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            chk("out_valid", 64'(out_valid), 1);
            chk("out_ch", 64'(out_ch), exp_q[0].ch);
            chk("out_sig", 64'(out_sig), exp_q[0].sig);
            chk("out_mv", 64'(out_mv), exp_q[0].mv);
            chk("out_dec", 64'(out_dec), exp_q[0].dec);
            void'(exp_q.pop_front());
        end else begin
            chk("out_valid", 64'(out_valid), 0);
        end
        chk("busy", 64'(busy), 64'((cyc >= last_acc) && (cyc < last_acc + CONV)));
        chk("blk_drop", 64'(blk_drop), 64'(cyc == drop_edge));
        if (out_valid) n_emit++;
        if (blk_drop) n_drop_seen++;
    endtask

    // Called at a falling edge: check the current cycle, then drive the next one.
    task automatic step(input logic v, input logic [DW-1:0] d);
        monitor();
        ad_valid = v;
        ad_data  = d;
        if (v) model_sample(d, cyc + 1);
        @(negedge ad_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DW'($urandom));
    endtask

    task automatic const_blk(input logic [AW-1:0] a, input logic [AW-1:0] b);
        for (int i = 0; i < BLK; i++) step(1'b1, {b, a});
        idle(40);
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_blk_drop", 64'(blk_drop), 0);
        chk("rst_out_ch", 64'(out_ch), 0);
        chk("rst_out_mv", 64'(out_mv), 0);
        chk("rst_out_dec", 64'(out_dec), 0);
        chk("rst_out_sig", 64'(out_sig), 43);
    endtask

    task automatic sweep_block(input logic [DW4-1:0] d);
        int t, k, s, mv, dec;
        ad_valid4 = 1'b1;
        ad_data4  = d;
        t = cyc + 1;
        @(negedge ad_clk);
        ad_valid4 = 1'b0;
        k = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid4) begin
                if (k < CH4) begin
                    ref_conv(sx(32'(d[k*AW4 +: AW4]), AW4), AW4, FS4, s, mv, dec);
                    chk("sw_edge", cyc, t + 3 + MVW4 + k * (4 + MVW4));
                    chk("sw_ch", 64'(out_ch4), k);
                    chk("sw_sig", 64'(out_sig4), s);
                    chk("sw_mv", 64'(out_mv4), mv);
                    chk("sw_dec", 64'(out_dec4), dec);
                end
                k++;
            end
            @(negedge ad_clk);
        end
        chk("sw_emits", k, CH4);
    endtask

    initial begin
        int i, guard, base;
        rst       = 1'b1;
        ad_valid  = 1'b0;
        ad_data   = '0;
        ad_valid4 = 1'b0;
        ad_data4  = '0;
        n_acc_blk = 0; n_drop = 0; n_emit = 0; n_drop_seen = 0;
        model_reset();
        repeat (3) @(negedge ad_clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge ad_clk);

        const_blk(12'h400, 12'h800);
        const_blk(12'hFFF, 12'hFFF);
        const_blk(12'h000, 12'h000);
        const_blk(12'h7FF, 12'h7FF);

        // Alternating full-scale codes with random gaps: average is exactly zero.
        i = 0;
        while (i < BLK) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, DW'($urandom));
            end else begin
                step(1'b1, (i % 2 == 0) ? {12'h7FF, 12'h7FF} : {12'h801, 12'h801});
                i++;
            end
        end
        idle(40);

        for (int j = 0; j < 64; j++) step(1'b1, DW'($urandom));
        idle(40);
        for (int j = 0; j < 600; j++) step($urandom_range(0, 3) != 0, DW'($urandom));
        idle(40);

        chk("emit_count", n_emit, CH * n_acc_blk);
        chk("drop_count", n_drop_seen, n_drop);
        chk("drops_seen", 64'(n_drop_seen > 0), 1);

        // Reset while ch0 is in its BCD phase, with a partial next block under way.
        base  = n_acc_blk;
        guard = 0;
        while (n_acc_blk == base && guard < 2 * BLK) begin
            step(1'b1, DW'($urandom));
            guard++;
        end
        chk("rst_setup", n_acc_blk, base + 1);
        for (int j = 0; j < 5; j++) step(1'b1, DW'($urandom));
        idle(3);
        ad_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge ad_clk);
        @(negedge ad_clk);
        rst = 1'b0;
        @(negedge ad_clk);
        for (int j = 0; j < BLK; j++) step(1'b1, DW'($urandom));
        idle(40);

        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            step(1'b0, '0);
            guard++;
        end
        chk("queue_drained", exp_q.size(), 0);

        sweep_block({CH4{14'h2000}});
        sweep_block(DW4'({$urandom, $urandom}));
        sweep_block(DW4'({$urandom, $urandom}));
        sweep_block({14'h1FFF, 14'h0000, 14'h3FFF, 14'h0001});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
